// File: rtl/bus_interface_unit.sv
// bus_interface_unit
//   Runs 8086-style T1..T4 bus cycles (with TW wait states) for one
//   request at a time. Odd-address word accesses become two byte cycles:
//   the odd address on the high lane, then address+1 on the low lane.
//   Every bus and response output is a register.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; accepted only in IDLE
//   req_addr/write/word/wdata request fields, latched on acceptance
//   rsp_valid/rdata/err       one-cycle completion pulse with read data / timeout
//   mem_addr/ale/rd_n/wr_n    external address, latch enable, strobes
//   mem_bhe_n                 high byte enable (active low)
//   mem_wdata/mem_wdata_oe    steered write data and its drive enable
//   mem_rdata/mem_ready       read data and ready, sampled in T3/TW
module bus_interface_unit #(
    parameter int WAIT_LIMIT = 15,
    parameter int ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              req_word,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ale,
    output logic              mem_rd_n,
    output logic              mem_wr_n,
    output logic              mem_bhe_n,
    output logic [15:0]       mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d, word_q, word_d;
    logic              second_q, second_d, err_q, err_d;
    logic [15:0]       wdata_q, wdata_d, data_q, data_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              ale_q, ale_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, bhe_n_q, bhe_n_d;
    logic [15:0]       mwd_q, mwd_d;
    logic              oe_q, oe_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;

    logic              split, last_piece;
    logic [15:0]       steer, cap;

    assign split = word_q & addr_q[0];

    // Lane steering for the piece currently on the bus. Second piece of a
    // split word is always the even address on the low lane.
    always_comb begin
        steer = {8'h00, wdata_q[7:0]};
        cap   = {8'h00, mem_rdata[7:0]};
        if (word_q && !addr_q[0]) begin
            steer = wdata_q;
            cap   = mem_rdata;
        end else if (second_q) begin
            steer = {8'h00, wdata_q[15:8]};
            cap   = {mem_rdata[7:0], data_q[7:0]};
        end else if (addr_q[0]) begin
            steer = {wdata_q[7:0], 8'h00};
            cap   = {data_q[15:8], mem_rdata[15:8]};
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        word_d      = word_q;
        second_d    = second_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        wcnt_d      = wcnt_q;
        mem_addr_d  = mem_addr_q;
        ale_d       = ale_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        bhe_n_d     = bhe_n_q;
        mwd_d       = mwd_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 16'h0000;
        last_piece  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    write_d    = req_write;
                    word_d     = req_word;
                    wdata_d    = req_wdata;
                    second_d   = 1'b0;
                    err_d      = 1'b0;
                    data_d     = 16'h0000;
                    wcnt_d     = '0;
                    mem_addr_d = req_addr;
                    ale_d      = 1'b1;
                    // High lane used by any word and by odd bytes.
                    bhe_n_d    = ~(req_word | req_addr[0]);
                    state_d    = S_T1;
                end
            end
            S_T1: begin
                ale_d   = 1'b0;
                rd_n_d  = write_q;
                wr_n_d  = ~write_q;
                oe_d    = write_q;
                mwd_d   = write_q ? steer : 16'h0000;
                state_d = S_T2;
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (mem_ready) begin
                    data_d     = cap;
                    last_piece = ~(split & ~second_q);
                    state_d    = S_T4;
                end else if ((WAIT_LIMIT != 0) && (wcnt_q == CW'(WAIT_LIMIT - 1))) begin
                    err_d   = 1'b1;
                    state_d = S_T4;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
                // Response registers load on the T3->T4 edge so the pulse
                // lines up with the T4 cycle.
                if (state_d == S_T4) begin
                    rd_n_d      = 1'b1;
                    wr_n_d      = 1'b1;
                    oe_d        = 1'b0;
                    mwd_d       = 16'h0000;
                    rsp_valid_d = last_piece;
                    rsp_err_d   = last_piece & err_d;
                    rsp_rdata_d = (last_piece && !write_q && !err_d) ? data_d : 16'h0000;
                end
            end
            S_T4: begin
                if (split && !second_q && !err_q) begin
                    second_d   = 1'b1;
                    wcnt_d     = '0;
                    mem_addr_d = addr_q + ADDR_W'(1);
                    ale_d      = 1'b1;
                    bhe_n_d    = 1'b1;
                    state_d    = S_T1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            second_q    <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= 16'h0000;
            data_q      <= 16'h0000;
            wcnt_q      <= '0;
            mem_addr_q  <= '0;
            ale_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            bhe_n_q     <= 1'b1;
            mwd_q       <= 16'h0000;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            word_q      <= word_d;
            second_q    <= second_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            wcnt_q      <= wcnt_d;
            mem_addr_q  <= mem_addr_d;
            ale_q       <= ale_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            bhe_n_q     <= bhe_n_d;
            mwd_q       <= mwd_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE) & ~rst;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_ale      = ale_q;
    assign mem_rd_n     = rd_n_q;
    assign mem_wr_n     = wr_n_q;
    assign mem_bhe_n    = bhe_n_q;
    assign mem_wdata    = mwd_q;
    assign mem_wdata_oe = oe_q;
endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
Executes 8086-style memory bus cycles for 20-bit physical addresses produced by the segment:offset address path. It accepts one read or write request at a time and drives a 16-bit multiplexed-style external bus (ALE, RD#, WR#, BHE#) through T1-T4 states with ready-driven wait states. Odd-address word accesses are split into two byte cycles. The unit returns read data, completion and timeout status to the execution side.

Parameters:
WAIT_LIMIT, 15, maximum TW (wait) cycles per bus cycle before abort; 0 = unlimited
ADDR_W, 20, physical address width (fixed at 20 for this design)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE and rst=0)
req_addr  in  20  physical byte address
req_write  in  1  1=write, 0=read
req_word  in  1  1=16-bit access, 0=byte
req_wdata  in  16  write data; byte writes use [7:0]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  16  read data; byte reads zero-extended; 0 for writes/errors
rsp_err  out  1  valid with rsp_valid; 1 = wait timeout
mem_addr  out  20  bus address (A0 included)
mem_ale  out  1  address latch enable
mem_rd_n  out  1  read strobe, active-low
mem_wr_n  out  1  write strobe, active-low
mem_bhe_n  out  1  high byte enable, active-low
mem_wdata  out  16  write data on bus lanes
mem_wdata_oe  out  1  write data drive enable
mem_rdata  in  16  bus read data
mem_ready  in  1  memory ready, sampled in T3/TW

Behaviour:
- Reset (synchronous, active-high): next state IDLE; all outputs registered to: mem_rd_n=1, mem_wr_n=1, mem_bhe_n=1, mem_ale=0, mem_wdata_oe=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=0 while rst=1. Reset mid-cycle aborts immediately: strobes deassert on the next edge, no rsp_valid issued.
- States: IDLE, T1, T2, T3 (includes TW), T4.
- IDLE: req_ready=1. On req_valid=1, latch addr/write/word/wdata; go T1. Requests only accepted in IDLE.
- T1: mem_addr=current byte address, mem_ale=1, mem_bhe_n per lane rule; go T2.
- T2: mem_ale=0; read: mem_rd_n=0; write: mem_wr_n=0, mem_wdata_oe=1, mem_wdata steered; go T3.
- T3: strobes held. mem_ready=1: capture read lane(s), go T4. mem_ready=0: stay (TW), increment wait counter; if WAIT_LIMIT!=0 and counter reaches WAIT_LIMIT, abort to T4 with error flag set.
- T4: mem_rd_n=1, mem_wr_n=1, mem_wdata_oe=0. If second piece of split access pending and no error: go T1 with address+1. Else rsp_valid=1 for this cycle with rsp_rdata/rsp_err, go IDLE.
- Lane rules: byte even: bhe_n=1, data on [7:0]. Byte odd: bhe_n=0, data on [15:8]. Word even: bhe_n=0, one cycle, full 16 bits. Word odd: cycle 1 at addr (odd, high lane) carries low byte; cycle 2 at addr+1 (even, bhe_n=1, low lane) carries high byte.
- Write steering: odd-byte lane receives source byte on [15:8]; unused lane driven 0.
- Address increment wraps modulo 2^20: 0xFFFFF+1 = 0x00000.
- Latency (mem_ready=1 throughout): single cycle access: acceptance edge, rsp_valid in 4th cycle after; split word: 8th. Each TW adds one.
- Timeout on first half of split word: second cycle not issued; rsp_err=1, rsp_rdata=0.
- Wait counter clears on every T1.
- req_valid changes while busy are ignored; latched request is authoritative.

Test Plan:
- Read word 0x12344, mem_rdata=0xBEEF, mem_ready=1 -> one T1-T4, bhe_n=0, rsp_valid 4 cycles after acceptance, rsp_rdata=0xBEEF, rsp_err=0.
- Write byte 0x00011, wdata=0x00A5 -> mem_addr=0x00011, bhe_n=0, mem_wdata=0xA500, wr_n low in T2-T3, rsp_valid with rsp_rdata=0.
- Read word 0xFFFFF, cycle-1 mem_rdata[15:8]=0x34, cycle-2 mem_rdata[7:0]=0x12 -> second mem_addr=0x00000, bhe_n=1 in cycle 2, rsp_rdata=0x1234 after 8 cycles.
- Read byte 0x00100, mem_ready low 3 cycles -> 3 TW cycles, rd_n held low, rsp_valid 7 cycles after acceptance, rsp_rdata=0x00xx.
- WAIT_LIMIT=15, mem_ready held 0 -> abort after 15 TW, rsp_err=1, rsp_rdata=0, strobes released in T4, req_ready=1 next cycle.
- rst asserted in T3 of a write -> next edge wr_n=1, oe=0, no rsp_valid; new request after rst drop completes normally.
